fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage with the IF/ID pipeline register; directly upstream of the decode/control unit.
- Owns the PC, drives a synchronous 1-cycle-latency instruction memory, and presents instr/pc/pc_plus4/valid to decode.
- Handles hazard-unit stalls without losing in-flight fetches via a 1-entry skid buffer.
- Handles branch/jump redirects from EX by squashing wrong-path fetches.

Parameters:
- DATA_WIDTH, 32, instruction width.
- ADDR_WIDTH, 32, PC/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold IF/ID and PC (from hazard unit).
- redirect  in  1  taken branch/jump resolved in EX.
- redirect_pc  in  ADDR_WIDTH  redirect target.
- imem_en  out  1  fetch request this cycle.
- imem_addr  out  ADDR_WIDTH  fetch address (= pc_q).
- imem_rdata  in  DATA_WIDTH  instruction word, valid the cycle after imem_en=1.
- if_id_instr  out  DATA_WIDTH  instruction to decode.
- if_id_pc  out  ADDR_WIDTH  PC of if_id_instr.
- if_id_pc_plus4  out  ADDR_WIDTH  if_id_pc+4.
- if_id_valid  out  1  if_id_instr is a real instruction.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - pc_q=RESET_PC; state=RUN; inflight=0; skid_valid=0.
  - if_id_instr=NOP_INSTR; if_id_pc=0; if_id_pc_plus4=0; if_id_valid=0.
  - imem_en=0 while rst=1.
- imem_en = !rst && !stall && !redirect && state!=REDIR (combinational). imem_addr=pc_q always.
- Fetch issue: when imem_en=1, at the edge pc_q<=pc_q+4 (modulo 2^ADDR_WIDTH, wraps silently), inflight<=1, inflight_pc<=pc_q. Otherwise inflight<=0.
- FSM states:
  - RUN: normal operation.
  - HOLD: stalled.
  - REDIR: one bubble cycle after a redirect.
- RUN, stall=0, redirect=0: IF/ID loads the source selected in this order:
  - skid_valid → skid contents;
  - else inflight → {imem_rdata, inflight_pc};
  - else NOP_INSTR with valid=0.
  - A loaded real instruction sets if_id_valid=1; a loaded bubble sets if_id_valid=0.
  - Clears skid_valid.
- stall=1 (no redirect) → HOLD:
  - IF/ID and pc_q hold; no new fetch.
  - If inflight=1, imem_rdata and inflight_pc are captured into the skid (skid_valid<=1).
  - Stall deassert → RUN; skid drains first, so no instruction is lost or duplicated.
- Skid capacity is 1; skid_valid && inflight never both true (assert).
- redirect=1: priority over stall, any state.
  - pc_q<=redirect_pc with bits [1:0] forced to 0.
  - IF/ID<=NOP_INSTR, if_id_valid<=0; skid_valid<=0; inflight<=0 (wrong-path fetch squashed); state→REDIR.
- REDIR:
  - imem_en=0 for that cycle; IF/ID holds the bubble; →RUN.
  - First target fetch issues the next cycle.
  - Redirect penalty from redirect cycle to target at IF/ID: 3 cycles.
- redirect during REDIR: re-applied and stays REDIR (last target wins).
- Reset mid-stall/mid-redirect: all state is discarded; fetch restarts at RESET_PC.
- if_id_pc_plus4 is registered alongside if_id_pc, never computed combinationally on the output.

Optional Feature:
- FETCH_MISALIGN_CHECK_EN defined:
  - Adds output port fetch_misaligned (1 bit, reset 0).
  - Registered one-cycle pulse the cycle after a redirect whose redirect_pc[1:0]!=0.
  - PC is still forced aligned.
- Undefined: port absent; low bits silently cleared.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INSTR constant;
  - fetch_state_t enum {RUN, HOLD, REDIR};
  - packed struct if_id_t {instr, pc, pc_plus4, valid}, shared with the decode stage.
- One sub-module: fetch_skid_buffer (1-entry if_id_t register with load/clear/valid), instantiated once.

Test Plan:
- Reset release, imem returns mem[A]=A^32'hDEAD0000 → imem_addr 0,4,8…; if_id_valid first 1 two edges after rst drops, with pc=0, pc_plus4=4.
- Stall for 3 cycles one cycle after fetching 0x10 → IF/ID holds 0x0C; after release, 0x10 then 0x14 each appear exactly once, no bubble.
- Redirect to 0x100 while IF/ID holds 0x20 → if_id_valid=0 for 3 cycles; next valid has pc=0x100; 0x24 is never presented.
- Redirect and stall asserted together → redirect wins: pc_q=0x100, skid cleared, state REDIR.
- pc_q=0xFFFF_FFFC fetch → next imem_addr=0x0000_0000 (wrap).
- FETCH_MISALIGN_CHECK_EN defined, redirect_pc=0x102 → fetch at 0x100 and fetch_misaligned=1 for exactly one cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage and the decode stage it feeds.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: NOP_INSTR bubble word, fetch_state_t FSM encoding, if_id_t IF/ID payload, if_id_bubble().
package fetch_pkg;

  localparam int FETCH_DATA_W = 32;
  localparam int FETCH_ADDR_W = 32;

  // addi x0,x0,0
  localparam logic [FETCH_DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    REDIR = 2'd2
  } fetch_state_t;

  // IF/ID payload. The decode stage reads these same field names.
  typedef struct packed {
    logic [FETCH_DATA_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_ADDR_W-1:0] pc_plus4;
    logic                    valid;
  } if_id_t;

  function automatic if_id_t if_id_bubble(input logic [FETCH_DATA_W-1:0] nop);
    if_id_t b;
    b.instr    = nop;
    b.pc       = '0;
    b.pc_plus4 = '0;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry holding register for a fetch that returns while decode is stalled.
// Latency: loaded data visible the cycle after load; clear takes effect the same way.
// Backpressure: none of its own; the parent never loads while dat_vld is set.
// Ports: clk, rst (sync, active-high), load, clear, din -> dat_vld, dat.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   clear,
  input  if_id_t din,
  output logic   dat_vld,
  output if_id_t dat
);

  logic   vld_q, vld_d;
  if_id_t dat_q, dat_d;

  // Clear wins over load: a redirect in the same cycle squashes the captured word.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (clear) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d = 1'b1;
      dat_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= if_id_bubble(NOP_INSTR);
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign dat_vld = vld_q;
  assign dat     = dat_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC ownership, 1-cycle sync imem fetch, IF/ID register with stall skid and redirect squash.
// Latency: fetch at PC to IF/ID is 2 edges; redirect to target at IF/ID is 3 cycles.
// Backpressure: stall holds PC and IF/ID; a fetch already in flight is parked in a 1-entry skid buffer.
// Ports: clk, rst, stall, redirect, redirect_pc, imem_en/imem_addr/imem_rdata, if_id_{instr,pc,pc_plus4,valid}.
// Optional: FETCH_MISALIGN_CHECK_EN adds fetch_misaligned, a one-cycle pulse after a misaligned redirect target.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                      DATA_WIDTH = 32,
  parameter int                      ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0]   NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [ADDR_WIDTH-1:0] if_id_pc,
  output logic [ADDR_WIDTH-1:0] if_id_pc_plus4,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic                  fetch_misaligned,
`endif
  output logic                  if_id_valid
);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;
  if_id_t                if_id_q, if_id_d;

  logic   skid_load, skid_clr, skid_vld;
  if_id_t rsp_dat, skid_dat;

  // No fetch while stalled, while redirecting, or during the post-redirect bubble.
  assign imem_en   = !rst && !stall && !redirect && (state_q != REDIR);
  assign imem_addr = pc_q;

  // The word returning from imem this cycle, tagged with the PC it was fetched from.
  always_comb begin
    rsp_dat.instr    = imem_rdata;
    rsp_dat.pc       = inflight_pc_q;
    rsp_dat.pc_plus4 = inflight_pc_q + ADDR_WIDTH'(4);
    rsp_dat.valid    = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if_id_d       = if_id_q;
    skid_load     = 1'b0;
    skid_clr      = 1'b0;

    if (imem_en) begin
      pc_d          = pc_q + ADDR_WIDTH'(4);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end

    if (redirect) begin
      // Squash everything on the wrong path; low PC bits are forced to word alignment.
      pc_d       = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      if_id_d    = if_id_bubble(NOP_INSTR);
      skid_clr   = 1'b1;
      inflight_d = 1'b0;
      state_d    = REDIR;
    end else if (stall) begin
      // Park a returning fetch so it is presented once the stall lifts.
      state_d   = HOLD;
      skid_load = inflight_q;
    end else if (state_q == REDIR) begin
      state_d = RUN;
    end else begin
      state_d  = RUN;
      skid_clr = 1'b1;
      if (skid_vld) begin
        if_id_d = skid_dat;
      end else if (inflight_q) begin
        if_id_d = rsp_dat;
      end else begin
        if_id_d = if_id_bubble(NOP_INSTR);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      if_id_q       <= if_id_bubble(NOP_INSTR);
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      if_id_q       <= if_id_d;
    end
  end

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clear   (skid_clr),
    .din     (rsp_dat),
    .dat_vld (skid_vld),
    .dat     (skid_dat)
  );

  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_valid    = if_id_q.valid;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = redirect && (redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign fetch_misaligned = misalign_q;
`endif

`ifndef SYNTHESIS
  // Fetches stop while the skid is occupied, so a parked word and a live fetch never coexist.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(skid_vld && inflight_q));
    end
  end
`endif

endmodule
